// File: rtl/pipeline_pkg.sv
// Shared types for the fetch/decode and decode/execute pipeline registers.
package pipeline_pkg;

  localparam int XLEN               = 64;
  localparam int REGISTER_SIZE      = 5;
  localparam int INSTRUCTION_LENGTH = XLEN / 2;

  // addi x0, x0, 0
  localparam logic [INSTRUCTION_LENGTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [XLEN-1:0]          alu_data_in_a;
    logic [XLEN-1:0]          alu_data_in_b;
    logic [XLEN-1:0]          jbl_data_in1;
    logic [XLEN-1:0]          jbl_data_in2;
    logic [XLEN-1:0]          jbl_address_in;
    logic [XLEN-1:0]          dm_write_data;
    logic [REGISTER_SIZE-1:0] destination_reg;
    logic                     dm_read_enable;
    logic                     dm_write_enable;
    logic                     rf_write_enable;
  } de_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, programmable step and saturation ceiling.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  // One extra bit so the overflow past MAX is visible before saturating.
  assign sum = {1'b0, count} + {1'b0, STEP};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (sum > {1'b0, MAX}) ? MAX : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hazard_pipeline_regs.sv
// F/D and D/E pipeline registers with stall bubbles, flush squash, protocol check and stall watchdog.
// Define HAZARD_PERF_COUNTERS_EN to build the bubble/flush performance counters.
module hazard_pipeline_regs
  import pipeline_pkg::*;
#(
  parameter int STALL_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          f_to_d_enable_ff,
  input  logic                          d_to_e_enable_ff,
  input  logic                          flush,
  input  logic [INSTRUCTION_LENGTH-1:0] fetch_instruction,
  input  logic [XLEN-1:0]               fetch_pc,
  input  de_payload_t                   d_payload,
  output logic [INSTRUCTION_LENGTH-1:0] decode_instruction,
  output logic [XLEN-1:0]               decode_pc,
  output logic                          decode_valid,
  output de_payload_t                   ex_payload,
  output logic                          ex_valid,
  output logic [1:0]                    stage_state,
  output logic                          protocol_error,
  output logic                          stall_timeout,
  output logic [31:0]                   bubble_count,
  output logic [31:0]                   flush_count
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  stage_state_t     state_nxt;
  logic             is_stall;
  logic             is_flush;
  logic [RUN_W-1:0] stall_run;

  always_comb begin
    state_nxt = ST_RUN;
    if (flush) begin
      state_nxt = ST_FLUSH;
    end else if (!d_to_e_enable_ff) begin
      state_nxt = ST_STALL;
    end
  end

  assign is_stall = (state_nxt == ST_STALL);
  assign is_flush = (state_nxt == ST_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decode_instruction <= NOP_INSTRUCTION;
      decode_pc          <= '0;
      decode_valid       <= 1'b0;
    end else if (flush) begin
      decode_instruction <= NOP_INSTRUCTION;
      decode_pc          <= '0;
      decode_valid       <= 1'b0;
    end else if (f_to_d_enable_ff) begin
      decode_instruction <= fetch_instruction;
      decode_pc          <= fetch_pc;
      decode_valid       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_payload <= '0;
      ex_valid   <= 1'b0;
    end else if (flush || !d_to_e_enable_ff) begin
      ex_payload <= '0;
      ex_valid   <= 1'b0;
    end else begin
      ex_payload <= d_payload;
      ex_valid   <= decode_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_state <= ST_RUN;
    end else begin
      stage_state <= state_nxt;
    end
  end

  sat_counter #(
    .WIDTH (RUN_W),
    .STEP  (RUN_W'(1)),
    .MAX   (RUN_W'(STALL_LIMIT))
  ) u_stall_run (
    .clk   (clk),
    .rst   (rst),
    .clr   (!is_stall),
    .inc   (is_stall),
    .count (stall_run)
  );

  // Trip on the edge that brings the run to the limit, not one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      protocol_error <= 1'b0;
      stall_timeout  <= 1'b0;
    end else begin
      if (!flush && (f_to_d_enable_ff != d_to_e_enable_ff)) begin
        protocol_error <= 1'b1;
      end
      if (is_stall && (stall_run >= RUN_W'(STALL_LIMIT - 1))) begin
        stall_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  sat_counter #(
    .WIDTH (32)
  ) u_bubble_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (is_stall),
    .count (bubble_count)
  );

  sat_counter #(
    .WIDTH (32)
  ) u_flush_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (is_flush),
    .count (flush_count)
  );
`else
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_pipeline_regs.sv
// Directed self-checking bench for hazard_pipeline_regs.
module tb_hazard_pipeline_regs;
  import pipeline_pkg::*;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                          clk;
  logic                          rst;
  logic                          f_to_d_enable_ff;
  logic                          d_to_e_enable_ff;
  logic                          flush;
  logic [INSTRUCTION_LENGTH-1:0] fetch_instruction;
  logic [XLEN-1:0]               fetch_pc;
  de_payload_t                   d_payload;
  logic [INSTRUCTION_LENGTH-1:0] decode_instruction;
  logic [XLEN-1:0]               decode_pc;
  logic                          decode_valid;
  de_payload_t                   ex_payload;
  logic                          ex_valid;
  logic [1:0]                    stage_state;
  logic                          protocol_error;
  logic                          stall_timeout;
  logic [31:0]                   bubble_count;
  logic [31:0]                   flush_count;

  int checks   = 0;
  int failures = 0;

  de_payload_t p0, p1, p2, p3, zero_pl;

  hazard_pipeline_regs #(.STALL_LIMIT(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .f_to_d_enable_ff   (f_to_d_enable_ff),
    .d_to_e_enable_ff   (d_to_e_enable_ff),
    .flush              (flush),
    .fetch_instruction  (fetch_instruction),
    .fetch_pc           (fetch_pc),
    .d_payload          (d_payload),
    .decode_instruction (decode_instruction),
    .decode_pc          (decode_pc),
    .decode_valid       (decode_valid),
    .ex_payload         (ex_payload),
    .ex_valid           (ex_valid),
    .stage_state        (stage_state),
    .protocol_error     (protocol_error),
    .stall_timeout      (stall_timeout),
    .bubble_count       (bubble_count),
    .flush_count        (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic de_payload_t make_pl(input logic [7:0] k);
    de_payload_t p;
    p.alu_data_in_a   = {8{k}};
    p.alu_data_in_b   = {8{k ^ 8'h11}};
    p.jbl_data_in1    = {8{k ^ 8'h22}};
    p.jbl_data_in2    = {8{k ^ 8'h33}};
    p.jbl_address_in  = {8{k ^ 8'h44}};
    p.dm_write_data   = {8{k ^ 8'h55}};
    p.destination_reg = k[4:0];
    p.dm_read_enable  = k[0];
    p.dm_write_enable = k[1];
    p.rf_write_enable = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] perf(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic cyc(input logic fe, input logic de, input logic fl,
                     input logic [31:0] ins, input logic [63:0] pc, input de_payload_t pl);
    f_to_d_enable_ff  = fe;
    d_to_e_enable_ff  = de;
    flush             = fl;
    fetch_instruction = ins;
    fetch_pc          = pc;
    d_payload         = pl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    p0 = make_pl(8'hA1);
    p1 = make_pl(8'hB2);
    p2 = make_pl(8'hC3);
    p3 = make_pl(8'hD4);
    zero_pl = '0;

    rst = 1'b0;
    f_to_d_enable_ff = 1'b0;
    d_to_e_enable_ff = 1'b0;
    flush = 1'b0;
    fetch_instruction = '0;
    fetch_pc = '0;
    d_payload = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dinstr", 512'(decode_instruction), 512'(32'h0000_0013));
    chk("rst_dvalid", 512'(decode_valid), 512'(1'b0));
    chk("rst_evalid", 512'(ex_valid), 512'(1'b0));
    chk("rst_state", 512'(stage_state), 512'(2'd0));
    chk("rst_bubble", 512'(bubble_count), 512'(32'd0));
    rst = 1'b1;

    // streaming
    cyc(1, 1, 0, 32'h0000_0111, 64'h100, zero_pl);
    chk("s1_dpc", 512'(decode_pc), 512'(64'h100));
    chk("s1_dvalid", 512'(decode_valid), 512'(1'b1));
    chk("s1_evalid", 512'(ex_valid), 512'(1'b0));
    cyc(1, 1, 0, 32'h0000_0222, 64'h104, p0);
    chk("s2_dpc", 512'(decode_pc), 512'(64'h104));
    chk("s2_epl", 512'(ex_payload), 512'(p0));
    chk("s2_evalid", 512'(ex_valid), 512'(1'b1));
    cyc(1, 1, 0, 32'h00A0_0093, 64'h108, p1);
    chk("s3_dpc", 512'(decode_pc), 512'(64'h108));
    chk("s3_epl", 512'(ex_payload), 512'(p1));
    chk("s3_state", 512'(stage_state), 512'(2'd0));

    // one-cycle load-use stall on 00A00093
    cyc(0, 0, 0, 32'h0000_0333, 64'h10C, p2);
    chk("st_dinstr", 512'(decode_instruction), 512'(32'h00A0_0093));
    chk("st_dpc", 512'(decode_pc), 512'(64'h108));
    chk("st_evalid", 512'(ex_valid), 512'(1'b0));
    chk("st_epl", 512'(ex_payload), 512'(zero_pl));
    chk("st_state", 512'(stage_state), 512'(2'd1));
    chk("st_bubble", 512'(bubble_count), 512'(perf(1)));
    cyc(1, 1, 0, 32'h0000_0333, 64'h10C, p2);
    chk("rel_dinstr", 512'(decode_instruction), 512'(32'h0000_0333));
    chk("rel_epl", 512'(ex_payload), 512'(p2));
    chk("rel_evalid", 512'(ex_valid), 512'(1'b1));
    chk("rel_bubble", 512'(bubble_count), 512'(perf(1)));
    chk("rel_perr", 512'(protocol_error), 512'(1'b0));

    // stall, then flush on the release edge
    cyc(0, 0, 0, 32'h0000_0444, 64'h110, p3);
    cyc(1, 1, 1, 32'h0000_0444, 64'h110, p3);
    chk("fr_dvalid", 512'(decode_valid), 512'(1'b0));
    chk("fr_dinstr", 512'(decode_instruction), 512'(32'h0000_0013));
    chk("fr_evalid", 512'(ex_valid), 512'(1'b0));
    chk("fr_state", 512'(stage_state), 512'(2'd2));
    chk("fr_flush", 512'(flush_count), 512'(perf(1)));
    chk("fr_bubble", 512'(bubble_count), 512'(perf(2)));

    // flush with both enables low
    cyc(0, 0, 1, 32'h0000_0555, 64'h200, p0);
    chk("f0_dpc", 512'(decode_pc), 512'(64'h0));
    chk("f0_state", 512'(stage_state), 512'(2'd2));
    chk("f0_flush", 512'(flush_count), 512'(perf(2)));
    chk("f0_bubble", 512'(bubble_count), 512'(perf(2)));

    // mismatched enables during flush are not a protocol error
    cyc(1, 0, 1, 32'h0000_0666, 64'h204, p0);
    chk("fm_perr", 512'(protocol_error), 512'(1'b0));
    chk("fm_flush", 512'(flush_count), 512'(perf(3)));

    // 7 stalls then RUN: no timeout
    cyc(1, 1, 0, 32'h0000_0777, 64'h300, p1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 32'h0000_0888, 64'h304, p1);
      chk("r7_tmo", 512'(stall_timeout), 512'(1'b0));
    end
    chk("r7_dinstr", 512'(decode_instruction), 512'(32'h0000_0777));
    cyc(1, 1, 0, 32'h0000_0888, 64'h304, p1);
    chk("r7_run_tmo", 512'(stall_timeout), 512'(1'b0));
    chk("r7_bubble", 512'(bubble_count), 512'(perf(9)));

    // 8 stalls: timeout rises on the 8th edge
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 32'h0000_0999, 64'h308, p2);
      chk("r8_tmo", 512'(stall_timeout), 512'((i == 8) ? 1'b1 : 1'b0));
    end
    cyc(1, 1, 0, 32'h0000_0999, 64'h308, p2);
    chk("r8_sticky", 512'(stall_timeout), 512'(1'b1));
    chk("r8_bubble", 512'(bubble_count), 512'(perf(17)));

    // protocol violation
    cyc(1, 0, 0, 32'h0000_0AAA, 64'h30C, p3);
    chk("pe_set", 512'(protocol_error), 512'(1'b1));
    chk("pe_dinstr", 512'(decode_instruction), 512'(32'h0000_0AAA));
    chk("pe_evalid", 512'(ex_valid), 512'(1'b0));
    chk("pe_state", 512'(stage_state), 512'(2'd1));
    cyc(1, 1, 0, 32'h0000_0BBB, 64'h310, p3);
    chk("pe_sticky", 512'(protocol_error), 512'(1'b1));
    chk("pe_epl", 512'(ex_payload), 512'(p3));

    // asynchronous reset in the middle of a stall
    cyc(0, 0, 0, 32'h0000_0CCC, 64'h314, p0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_dinstr", 512'(decode_instruction), 512'(32'h0000_0013));
    chk("ar_dvalid", 512'(decode_valid), 512'(1'b0));
    chk("ar_state", 512'(stage_state), 512'(2'd0));
    chk("ar_perr", 512'(protocol_error), 512'(1'b0));
    chk("ar_tmo", 512'(stall_timeout), 512'(1'b0));
    chk("ar_bubble", 512'(bubble_count), 512'(32'd0));
    chk("ar_flush", 512'(flush_count), 512'(32'd0));
    #2;
    rst = 1'b1;
    cyc(1, 1, 0, 32'h0000_0DDD, 64'h400, p1);
    chk("pr_dpc", 512'(decode_pc), 512'(64'h400));
    chk("pr_evalid", 512'(ex_valid), 512'(1'b0));
    chk("pr_epl", 512'(ex_payload), 512'(p1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_pipeline_regs.md
# hazard_pipeline_regs

Fetch/decode and decode/execute pipeline register pair that consumes the hazard unit's stall enables and forwarded operands. On a load-use stall it holds the decode stage and injects a bubble into execute. On a taken branch or jump it squashes both stages. It also checks the stall protocol and enforces a stall watchdog. The block sits between the instruction fetch, the hazard mitigation unit and the execute stage.

## Interface
- XLEN, 64, datapath width
- REGISTER_SIZE, 5, register index width
- INSTRUCTION_LENGTH, XLEN/2, instruction width
- STALL_LIMIT, 8, consecutive stall edges before the watchdog trips
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-low
- f_to_d_enable_ff  input  1  fetch-to-decode load enable from the hazard unit
- d_to_e_enable_ff  input  1  decode-to-execute load enable from the hazard unit
- flush  input  1  taken branch or jump resolved in execute
- fetch_instruction  input  INSTRUCTION_LENGTH  instruction from fetch
- fetch_pc  input  XLEN  PC of fetch_instruction
- d_payload  input  $bits(de_payload_t)  forwarded operands and control from decode/hazard unit
- decode_instruction  output  INSTRUCTION_LENGTH  registered instruction in decode
- decode_pc  output  XLEN  registered PC in decode
- decode_valid  output  1  decode slot holds a real instruction
- ex_payload  output  $bits(de_payload_t)  registered payload in execute
- ex_valid  output  1  execute slot holds a real instruction
- stage_state  output  2  stage_state_t of the last edge's action
- protocol_error  output  1  sticky; the two enables disagreed
- stall_timeout  output  1  sticky; the stall watchdog tripped
- bubble_count  output  32  execute bubbles injected (see Configuration)
- flush_count  output  32  flushes taken (see Configuration)

## Operation
- de_payload_t fields:
  - alu_data_in_a, alu_data_in_b, jbl_data_in1, jbl_data_in2, jbl_address_in, dm_write_data: each XLEN bits
  - destination_reg: REGISTER_SIZE bits
  - dm_read_enable, dm_write_enable, rf_write_enable: 1 bit each
- Bubble: payload all zero, destination_reg 0, ex_valid 0.
- Fetch/decode register, per edge, in priority order:
  - flush: decode_instruction = NOP (32'h00000013), decode_pc = 0, decode_valid = 0
  - else f_to_d_enable_ff = 1: load fetch_instruction and fetch_pc, decode_valid = 1
  - else: hold all three.
- Decode/execute register, per edge, in priority order:
  - flush: bubble
  - else d_to_e_enable_ff = 0: bubble
  - else: ex_payload = d_payload, ex_valid = decode_valid.
- stage_state FSM:
  - Registered; transitions every edge, independent of the previous state.
  - RUN (2'd0) on a normal load, STALL (2'd1) on a stall bubble, FLUSH (2'd2) on a flush. 2'd3 is unused.
  - Flush together with a stall goes to FLUSH.
- Protocol check: on any edge with f_to_d_enable_ff != d_to_e_enable_ff and flush = 0, set protocol_error. Both registers still follow their own enable.
- Watchdog:
  - stall_run is a counter of consecutive STALL edges, width $clog2(STALL_LIMIT+1); any RUN or FLUSH edge clears it.
  - When stall_run reaches STALL_LIMIT, set stall_timeout.
  - stall_run saturates at STALL_LIMIT.
- Sticky flags (protocol_error, stall_timeout) clear only on reset.

## Timing
- Reset: all outputs 0, except decode_instruction = NOP and stage_state = RUN.
- Reset takes effect immediately and asynchronously, even mid-stall or mid-flush. The first edge after release behaves normally.
- Latency: fetch to decode 1 cycle; decode to execute 1 cycle.
- Back-to-back stalls hold decode indefinitely; each held cycle injects one bubble.
- A flush on the same edge as a stall release discards the held instruction.

## Configuration
- HAZARD_PERF_COUNTERS_EN:
  - Defined: bubble_count increments on each STALL edge and flush_count on each FLUSH edge. Both are 32-bit and saturate at 32'hFFFFFFFF.
  - Undefined: both ports tied to 0 and no counter flops are built.

## Structure
- pipeline_pkg holds de_payload_t, stage_state_t, and the NOP_INSTRUCTION constant.
- Sub-module sat_counter (parameterised width, increment, saturation) is used for stall_run and both performance counters.

## Test plan
- Reset low mid-stream: decode_instruction = 32'h00000013, all valids 0, stage_state RUN, counters 0.
- Both enables 0 for 1 cycle with decode holding 32'h00A00093:
  - decode holds the instruction; ex_valid = 0 and ex_payload = 0 for one cycle
  - next edge executes it; bubble_count = 1.
- flush = 1 with both enables 0: decode_valid = 0, ex_valid = 0, stage_state FLUSH, flush_count = 1, bubble_count unchanged.
- f_to_d_enable_ff = 1, d_to_e_enable_ff = 0 for one edge: protocol_error = 1 and stays 1 until reset.
- Both enables 0 for 8 consecutive edges with STALL_LIMIT = 8: stall_timeout rises on the 8th edge. A run of 7 stalls followed by RUN leaves it 0.
- Streaming with fetch_pc = 0x100, 0x104, 0x108: decode_pc follows one cycle later, and ex_payload matches d_payload one cycle after that.
